// File: rtl/toaplan2_rom_arbiter.sv
// toaplan2_rom_arbiter
//   N-channel ROM read arbiter sharing one SDRAM bank between graphics/PCM
//   fetch clients. Each channel has a one-entry cache (tag + data). A hit
//   gives CH_OK one cycle after the request. A miss queues one SDRAM read,
//   and only one read is outstanding at a time.
//
// Ports
//   CLK        system clock
//   RESET      asynchronous reset, active-low
//   CH_CS      per-channel read request (held while data is wanted)
//   CH_ADDR    per-channel word address, channel i at [i*AW +: AW]
//   CH_OK      per-channel data-valid for the current CH_ADDR (registered)
//   CH_DOUT    per-channel cached data, channel i at [i*DW +: DW]
//   BA_ADDR    SDRAM word address (AW zero-extended/truncated to 22 bits)
//   BA_RD      SDRAM read request, held until BA_ACK
//   BA_ACK     SDRAM accepted the request
//   BA_DOK     DATA_READ valid this cycle
//   BA_RDY     burst complete
//   DATA_READ  SDRAM read data
module toaplan2_rom_arbiter #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned AW        = 22,
    parameter int unsigned DW        = 32,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NCH-1:0]    CH_CS,
    input  logic [NCH*AW-1:0] CH_ADDR,
    output logic [NCH-1:0]    CH_OK,
    output logic [NCH*DW-1:0] CH_DOUT,
    output logic [21:0]       BA_ADDR,
    output logic              BA_RD,
    input  logic              BA_ACK,
    input  logic              BA_DOK,
    input  logic              BA_RDY,
    input  logic [15:0]       DATA_READ
);

    localparam int unsigned IW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned NBEAT = DW / 16;

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

    state_t         state;
    logic [NCH-1:0] valid;
    logic [NCH-1:0] hit;
    logic [NCH-1:0] miss;
    logic [AW-1:0]  tag  [NCH];
    logic [DW-1:0]  data [NCH];
    logic [DW-1:0]  beat_buf;
    logic [1:0]     beat_cnt;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  gidx;
    logic [AW-1:0]  gaddr;

    logic [IW-1:0]  shamt;
    logic [NCH-1:0] rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;
    logic [IW-1:0]  gnt;
    logic [AW-1:0]  gnt_addr;

    always_comb begin
        hit     = '0;
        miss    = '0;
        CH_DOUT = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            hit[i]              = CH_CS[i] & valid[i] & (tag[i] == CH_ADDR[i*AW +: AW]);
            miss[i]             = CH_CS[i] & ~hit[i];
            CH_DOUT[i*DW +: DW] = data[i];
        end
    end

    // Rotate the miss vector so the search origin (PTR, or 0 in fixed-priority
    // mode) sits at bit 0, pick the lowest set bit, then rotate the offset back.
    always_comb begin
        shamt = (PRIO_MODE != 0) ? '0 : ptr;
        rot   = NCH'({miss, miss} >> shamt);
        off   = '0;
        for (int unsigned k = NCH; k > 0; k--) begin
            if (rot[k-1]) off = IW'(k - 1);
        end
        sum = {1'b0, shamt} + {1'b0, off};
        if (sum >= (IW+1)'(NCH)) sum = sum - (IW+1)'(NCH);
        gnt      = sum[IW-1:0];
        gnt_addr = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (gnt == IW'(i)) gnt_addr = CH_ADDR[i*AW +: AW];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            BA_RD    <= 1'b0;
            BA_ADDR  <= '0;
            CH_OK    <= '0;
            valid    <= '0;
            ptr      <= '0;
            gidx     <= '0;
            gaddr    <= '0;
            beat_buf <= '0;
            beat_cnt <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                tag[i]  <= '0;
                data[i] <= '0;
            end
        end else begin
            CH_OK <= hit;
            case (state)
                IDLE: begin
                    if (|miss) begin
                        gidx     <= gnt;
                        gaddr    <= gnt_addr;
                        BA_ADDR  <= 22'(gnt_addr);
                        BA_RD    <= 1'b1;
                        beat_cnt <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (BA_ACK) begin
                        BA_RD <= 1'b0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    // The beat buffer is not cleared per transfer: a short
                    // burst leaves the upper half from the previous fill.
                    if (BA_DOK) begin
                        for (int unsigned b = 0; b < NBEAT; b++) begin
                            if (beat_cnt == 2'(b)) beat_buf[b*16 +: 16] <= DATA_READ;
                        end
                        if (beat_cnt != 2'd2) beat_cnt <= beat_cnt + 2'd1;
                    end
                    if (BA_RDY) state <= DONE;
                end
                DONE: begin
                    for (int unsigned i = 0; i < NCH; i++) begin
                        if (gidx == IW'(i)) begin
                            tag[i]   <= gaddr;
                            data[i]  <= beat_buf;
                            valid[i] <= 1'b1;
                        end
                    end
                    ptr   <= (gidx == IW'(NCH - 1)) ? '0 : gidx + IW'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_toaplan2_rom_arbiter.sv
module tb_toaplan2_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ack, dok, rdy;
    logic [15:0] dat;

    logic [3:0]   cs_a, cs_b, ok_a, ok_b;
    logic [1:0]   cs_c, ok_c;
    logic [87:0]  addr_a, addr_b;
    logic [43:0]  addr_c;
    logic [127:0] dout_a, dout_b;
    logic [31:0]  dout_c;
    logic [21:0]  ba_addr_a, ba_addr_b, ba_addr_c;
    logic         ba_rd_a, ba_rd_b, ba_rd_c;

    int n_cmp = 0;
    int n_err = 0;
    int sel   = 0;

    logic        cur_rd;
    logic [21:0] cur_addr;
    logic [3:0]  cur_ok;

    always #5 clk = ~clk;

    toaplan2_rom_arbiter #(.NCH(4), .AW(22), .DW(32), .PRIO_MODE(0)) dut_a (
        .CLK(clk), .RESET(rst_n), .CH_CS(cs_a), .CH_ADDR(addr_a), .CH_OK(ok_a),
        .CH_DOUT(dout_a), .BA_ADDR(ba_addr_a), .BA_RD(ba_rd_a), .BA_ACK(ack),
        .BA_DOK(dok), .BA_RDY(rdy), .DATA_READ(dat));

    toaplan2_rom_arbiter #(.NCH(4), .AW(22), .DW(32), .PRIO_MODE(1)) dut_b (
        .CLK(clk), .RESET(rst_n), .CH_CS(cs_b), .CH_ADDR(addr_b), .CH_OK(ok_b),
        .CH_DOUT(dout_b), .BA_ADDR(ba_addr_b), .BA_RD(ba_rd_b), .BA_ACK(ack),
        .BA_DOK(dok), .BA_RDY(rdy), .DATA_READ(dat));

    toaplan2_rom_arbiter #(.NCH(2), .AW(22), .DW(16), .PRIO_MODE(0)) dut_c (
        .CLK(clk), .RESET(rst_n), .CH_CS(cs_c), .CH_ADDR(addr_c), .CH_OK(ok_c),
        .CH_DOUT(dout_c), .BA_ADDR(ba_addr_c), .BA_RD(ba_rd_c), .BA_ACK(ack),
        .BA_DOK(dok), .BA_RDY(rdy), .DATA_READ(dat));

    // SDRAM-side inputs are shared; only the selected instance ever has a request active.
    always_comb begin
        case (sel)
            0:       begin cur_rd = ba_rd_a; cur_addr = ba_addr_a; cur_ok = ok_a; end
            1:       begin cur_rd = ba_rd_b; cur_addr = ba_addr_b; cur_ok = ok_b; end
            default: begin cur_rd = ba_rd_c; cur_addr = ba_addr_c; cur_ok = {2'b00, ok_c}; end
        endcase
    end

    function automatic logic [31:0] get_dout(input int s, input int ch);
        case (s)
            0:       return dout_a[ch*32 +: 32];
            1:       return dout_b[ch*32 +: 32];
            default: return {16'h0000, dout_c[ch*16 +: 16]};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int s, input int ch, input logic [21:0] a, input logic c);
        case (s)
            0:       begin cs_a[ch] = c; addr_a[ch*22 +: 22] = a; end
            1:       begin cs_b[ch] = c; addr_b[ch*22 +: 22] = a; end
            default: begin cs_c[ch] = c; addr_c[ch*22 +: 22] = a; end
        endcase
    endtask

    task automatic wait_rd(input string nm);
        int n = 0;
        while (!cur_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!cur_rd) begin
            n_err++;
            $display("FAIL %s: BA_RD=0 after 20 cycles, required 1", nm);
        end
    endtask

    // Called at a negedge with BA_RD high. Returns at the negedge where CH_OK
    // reflects the freshly written cache entry.
    task automatic serve(input int nb, input logic [15:0] b0, input logic [15:0] b1,
                         input bit merge, input bit chg, input int cch, input logic [21:0] caddr);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("rd_drop_after_ack", 64'(cur_rd), 64'(0));
        if (chg) set_req(sel, cch, caddr, 1'b1);
        for (int b = 0; b < nb; b++) begin
            dok = 1'b1;
            dat = (b == 0) ? b0 : b1;
            if (merge && b == nb - 1) rdy = 1'b1;
            @(negedge clk);
            dok = 1'b0;
            rdy = 1'b0;
        end
        if (!(merge && nb > 0)) begin
            rdy = 1'b1;
            @(negedge clk);
            rdy = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        int          s;
        int          ch;
        logic [21:0] addr;
        int          nb;
        logic [15:0] b0;
        logic [15:0] b1;
        bit          merge;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{0, 1, 22'h001234, 2, 16'hBEEF, 16'hCAFE, 1'b0, 32'hCAFEBEEF};
        vt[1] = '{0, 0, 22'h000100, 2, 16'h1111, 16'h2222, 1'b1, 32'h22221111};
        vt[2] = '{0, 2, 22'h3FFFFF, 1, 16'h3333, 16'h0000, 1'b0, 32'h22223333};
        vt[3] = '{0, 3, 22'h000000, 0, 16'h0000, 16'h0000, 1'b0, 32'h22223333};
        vt[4] = '{0, 1, 22'h001235, 1, 16'h4444, 16'h0000, 1'b1, 32'h22224444};
        vt[5] = '{2, 0, 22'h000077, 2, 16'h55AA, 16'h1234, 1'b0, 32'h000055AA};

        rst_n = 1'b0;
        ack = 1'b0; dok = 1'b0; rdy = 1'b0; dat = '0;
        cs_a = '0; cs_b = '0; cs_c = '0;
        addr_a = '0; addr_b = '0; addr_c = '0;
        repeat (3) @(negedge clk);
        chk("reset_ba_rd", 64'(ba_rd_a), 64'(0));
        chk("reset_ba_addr", 64'(ba_addr_a), 64'(0));
        chk("reset_ch_ok", 64'(ok_a), 64'(0));
        chk("reset_dout", 64'(dout_a), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            sel = vt[i].s;
            set_req(sel, vt[i].ch, vt[i].addr, 1'b1);
            wait_rd($sformatf("v%0d_rd", i));
            chk($sformatf("v%0d_ba_addr", i), 64'(cur_addr), 64'(vt[i].addr));
            @(negedge clk);
            chk($sformatf("v%0d_rd_held", i), 64'(cur_rd), 64'(1));
            chk($sformatf("v%0d_addr_held", i), 64'(cur_addr), 64'(vt[i].addr));
            serve(vt[i].nb, vt[i].b0, vt[i].b1, vt[i].merge, 1'b0, 0, '0);
            chk($sformatf("v%0d_ok", i), 64'(cur_ok[vt[i].ch]), 64'(1));
            chk($sformatf("v%0d_dout", i), 64'(get_dout(sel, vt[i].ch)), 64'(vt[i].exp));
            set_req(sel, vt[i].ch, vt[i].addr, 1'b0);
            @(negedge clk);
        end

        // Cache hit: no SDRAM traffic, CH_OK the cycle after CS.
        sel = 0;
        set_req(0, 1, 22'h001235, 1'b1);
        @(negedge clk);
        chk("hit_ok", 64'(ok_a[1]), 64'(1));
        chk("hit_dout", 64'(get_dout(0, 1)), 64'(32'h22224444));
        chk("hit_no_rd", 64'(ba_rd_a), 64'(0));
        repeat (3) @(negedge clk);
        chk("hit_no_rd_later", 64'(ba_rd_a), 64'(0));
        set_req(0, 1, 22'h001235, 1'b0);
        @(negedge clk);

        // Address change after ACK: cache takes the latched address.
        set_req(0, 2, 22'h000100, 1'b1);
        wait_rd("chg_rd");
        chk("chg_ba_addr", 64'(ba_addr_a), 64'(22'h000100));
        serve(2, 16'hAAAA, 16'hBBBB, 1'b0, 1'b1, 2, 22'h000104);
        chk("chg_ok_low", 64'(ok_a[2]), 64'(0));
        chk("chg_rereq_rd", 64'(ba_rd_a), 64'(1));
        chk("chg_rereq_addr", 64'(ba_addr_a), 64'(22'h000104));
        set_req(0, 2, 22'h000100, 1'b1);
        @(negedge clk);
        chk("chg_old_tag_hit", 64'(ok_a[2]), 64'(1));
        chk("chg_old_data", 64'(get_dout(0, 2)), 64'(32'hBBBBAAAA));
        set_req(0, 2, 22'h000100, 1'b0);
        serve(2, 16'h0001, 16'h0002, 1'b0, 1'b0, 0, '0);

        // Reset in the middle of DATA after one beat.
        set_req(0, 1, 22'h000222, 1'b1);
        wait_rd("rst_rd");
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        dok = 1'b1; dat = 16'h9999;
        @(negedge clk);
        dok = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ba_rd", 64'(ba_rd_a), 64'(0));
        chk("rst_mid_ok", 64'(ok_a), 64'(0));
        chk("rst_mid_ba_addr", 64'(ba_addr_a), 64'(0));
        set_req(0, 1, 22'h000222, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rdy = 1'b1; dok = 1'b1; dat = 16'h7777;
        @(negedge clk);
        rdy = 1'b0; dok = 1'b0;
        chk("late_rdy_no_rd", 64'(ba_rd_a), 64'(0));
        @(negedge clk);
        chk("late_rdy_ok", 64'(ok_a), 64'(0));
        chk("late_rdy_dout", 64'(get_dout(0, 1)), 64'(0));
        set_req(0, 1, 22'h000222, 1'b1);
        wait_rd("rst_fresh_rd");
        chk("rst_fresh_addr", 64'(ba_addr_a), 64'(22'h000222));
        serve(2, 16'h1111, 16'h2222, 1'b0, 1'b0, 0, '0);
        chk("rst_fresh_ok", 64'(ok_a[1]), 64'(1));
        chk("rst_fresh_dout", 64'(get_dout(0, 1)), 64'(32'h22221111));
        set_req(0, 1, 22'h000222, 1'b0);

        // Round-robin contention from PTR=0.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 4; c++) set_req(0, c, 22'((c + 1) * 16), 1'b1);
        for (int g = 0; g < 4; g++) begin
            wait_rd($sformatf("rr%0d_rd", g));
            chk($sformatf("rr%0d_grant_addr", g), 64'(ba_addr_a), 64'((g + 1) * 16));
            serve(2, 16'(g), 16'hA000, 1'b0, (g == 3), 0, 22'h000050);
        end
        chk("rr_ok_after_round", 64'(ok_a), 64'(4'b1110));
        wait_rd("rr_refill_rd");
        chk("rr_refill_ch0_next", 64'(ba_addr_a), 64'(22'h000050));
        serve(2, 16'h0005, 16'hA000, 1'b0, 1'b0, 0, '0);
        chk("rr_ok_all", 64'(ok_a), 64'(4'b1111));
        chk("rr_dout_ch3", 64'(get_dout(0, 3)), 64'(32'hA0000003));
        cs_a = '0;
        @(negedge clk);

        // Fixed priority: ch0 keeps missing, ch3 waits.
        sel = 1;
        set_req(1, 3, 22'h0003F0, 1'b1);
        set_req(1, 0, 22'h0000A0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_rd($sformatf("prio%0d_rd", k));
            chk($sformatf("prio%0d_ch0_wins", k), 64'(ba_addr_b), 64'(22'h0000A0 + k));
            serve(2, 16'h00B0, 16'h00B1, 1'b0, 1'b1, 0, 22'(32'hA1 + k));
        end
        wait_rd("prio_last_ch0_rd");
        chk("prio_last_ch0_addr", 64'(ba_addr_b), 64'(22'h0000A4));
        set_req(1, 0, 22'h0000A4, 1'b0);
        serve(2, 16'h00B0, 16'h00B1, 1'b0, 1'b0, 0, '0);
        wait_rd("prio_ch3_rd");
        chk("prio_ch3_addr", 64'(ba_addr_b), 64'(22'h0003F0));
        serve(2, 16'h0033, 16'h0044, 1'b0, 1'b0, 0, '0);
        chk("prio_ch3_ok", 64'(ok_b[3]), 64'(1));
        chk("prio_ch3_dout", 64'(get_dout(1, 3)), 64'(32'h00440033));
        cs_b = '0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
